// File: rtl/operand_fetch_pkg.sv
// rtl/operand_fetch_pkg.sv - shared widths, zero-register index and skid state encoding
package operand_fetch_pkg;

    localparam logic [4:0] ZERO_REG   = 5'd0;
    localparam int         DEF_DATA_W = 32;
    localparam int         DEF_ADDR_W = 5;
    localparam int         DEF_TAG_W  = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/operand_skid_buffer.sv
// rtl/operand_skid_buffer.sv - two-entry operand FIFO; held-operand refresh when OPERAND_BYPASS_EN
module operand_skid_buffer
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_rs,
    input  logic [ADDR_W-1:0] push_rt,
    input  logic [DATA_W-1:0] push_a,
    input  logic [DATA_W-1:0] push_b,
    input  logic [TAG_W-1:0]  push_tag,
`ifdef OPERAND_BYPASS_EN
    input  logic              refresh_en,
    input  logic [ADDR_W-1:0] refresh_reg1,
    input  logic [ADDR_W-1:0] refresh_reg2,
    input  logic [DATA_W-1:0] refresh_data1,
    input  logic [DATA_W-1:0] refresh_data2,
`endif
    output skid_state_t       state,
    output logic [DATA_W-1:0] head_a,
    output logic [DATA_W-1:0] head_b,
    output logic [TAG_W-1:0]  head_tag
);

    logic [ADDR_W-1:0] rs_q  [2];
    logic [ADDR_W-1:0] rt_q  [2];
    logic [DATA_W-1:0] a_q   [2];
    logic [DATA_W-1:0] b_q   [2];
    logic [TAG_W-1:0]  tag_q [2];
    logic [DATA_W-1:0] a_r   [2];
    logic [DATA_W-1:0] b_r   [2];

    // Port 2 is checked first so a dual write to one register keeps the port-2 value.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            a_r[i] = a_q[i];
            b_r[i] = b_q[i];
`ifdef OPERAND_BYPASS_EN
            if (refresh_en && rs_q[i] != ADDR_W'(ZERO_REG)) begin
                if (rs_q[i] == refresh_reg2)      a_r[i] = refresh_data2;
                else if (rs_q[i] == refresh_reg1) a_r[i] = refresh_data1;
            end
            if (refresh_en && rt_q[i] != ADDR_W'(ZERO_REG)) begin
                if (rt_q[i] == refresh_reg2)      b_r[i] = refresh_data2;
                else if (rt_q[i] == refresh_reg1) b_r[i] = refresh_data1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
            for (int i = 0; i < 2; i++) begin
                rs_q[i]  <= '0;
                rt_q[i]  <= '0;
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            a_q[0] <= a_r[0];
            b_q[0] <= b_r[0];
            a_q[1] <= a_r[1];
            b_q[1] <= b_r[1];
            if (push && (pop || state == EMPTY)) begin
                // Only legal from ONE (pop) or EMPTY (no pop): new entry lands at the head.
                rs_q[0]  <= push_rs;
                rt_q[0]  <= push_rt;
                a_q[0]   <= push_a;
                b_q[0]   <= push_b;
                tag_q[0] <= push_tag;
                state    <= ONE;
            end else if (push) begin
                rs_q[1]  <= push_rs;
                rt_q[1]  <= push_rt;
                a_q[1]   <= push_a;
                b_q[1]   <= push_b;
                tag_q[1] <= push_tag;
                state    <= TWO;
            end else if (pop) begin
                if (state == TWO) begin
                    rs_q[0]  <= rs_q[1];
                    rt_q[0]  <= rt_q[1];
                    a_q[0]   <= a_r[1];
                    b_q[0]   <= b_r[1];
                    tag_q[0] <= tag_q[1];
                    state    <= ONE;
                end else begin
                    state <= EMPTY;
                end
            end
        end
    end

    assign head_a   = a_q[0];
    assign head_b   = b_q[0];
    assign head_tag = tag_q[0];

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand read front end with skid buffer; OPERAND_BYPASS_EN adds write-back forwarding
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [ADDR_W-1:0] rf_read_register1,
    output logic [ADDR_W-1:0] rf_read_register2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_reg1,
    input  logic [ADDR_W-1:0] wb_reg2,
    input  logic [DATA_W-1:0] wb_data1,
    input  logic [DATA_W-1:0] wb_data2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [TAG_W-1:0]  out_tag
);

    skid_state_t       state;
    logic              accept;
    logic              retire;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    assign rf_read_register1 = in_rs;
    assign rf_read_register2 = in_rt;
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign retire    = out_valid && out_ready;

    always_comb begin
        sel_a = rf_read_data1;
        sel_b = rf_read_data2;
`ifdef OPERAND_BYPASS_EN
        if (wb_en && in_rs == wb_reg2)      sel_a = wb_data2;
        else if (wb_en && in_rs == wb_reg1) sel_a = wb_data1;
        if (wb_en && in_rt == wb_reg2)      sel_b = wb_data2;
        else if (wb_en && in_rt == wb_reg1) sel_b = wb_data1;
`endif
        if (in_rs == ADDR_W'(ZERO_REG)) sel_a = '0;
        if (in_rt == ADDR_W'(ZERO_REG)) sel_b = '0;
    end

`ifndef OPERAND_BYPASS_EN
    logic unused_wb;
    assign unused_wb = ^{wb_en, wb_reg1, wb_reg2, wb_data1, wb_data2};
`endif

    operand_skid_buffer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TAG_W  (TAG_W)
    ) u_skid (
        .clk           (clk),
        .reset         (reset),
        .push          (accept),
        .pop           (retire),
        .push_rs       (in_rs),
        .push_rt       (in_rt),
        .push_a        (sel_a),
        .push_b        (sel_b),
        .push_tag      (in_tag),
`ifdef OPERAND_BYPASS_EN
        .refresh_en    (wb_en),
        .refresh_reg1  (wb_reg1),
        .refresh_reg2  (wb_reg2),
        .refresh_data1 (wb_data1),
        .refresh_data2 (wb_data2),
`endif
        .state         (state),
        .head_a        (out_a),
        .head_b        (out_b),
        .head_tag      (out_tag)
    );

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - scoreboard bench for operand_fetch with a register file model
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs, in_rt;
    logic [7:0]  in_tag;
    logic [4:0]  rf_read_register1, rf_read_register2;
    logic [31:0] rf_read_data1, rf_read_data2;
    logic        wb_en;
    logic [4:0]  wb_reg1, wb_reg2;
    logic [31:0] wb_data1, wb_data2;
    logic        out_valid, out_ready;
    logic [31:0] out_a, out_b;
    logic [7:0]  out_tag;
    logic        rand_ready = 1'b0;

    logic [31:0] rf [32];

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  tag;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_rs             (in_rs),
        .in_rt             (in_rt),
        .in_tag            (in_tag),
        .rf_read_register1 (rf_read_register1),
        .rf_read_register2 (rf_read_register2),
        .rf_read_data1     (rf_read_data1),
        .rf_read_data2     (rf_read_data2),
        .wb_en             (wb_en),
        .wb_reg1           (wb_reg1),
        .wb_reg2           (wb_reg2),
        .wb_data1          (wb_data1),
        .wb_data2          (wb_data2),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_a             (out_a),
        .out_b             (out_b),
        .out_tag           (out_tag)
    );

    assign rf_read_data1 = rf[rf_read_register1];
    assign rf_read_data2 = rf[rf_read_register2];

    // Register file: port 2 written last so it wins on a shared index.
    always @(posedge clk) begin
        if (wb_en) begin
            rf[wb_reg1] <= wb_data1;
            rf[wb_reg2] <= wb_data2;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model_sel(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef OPERAND_BYPASS_EN
        if (wb_en && idx == wb_reg2) return wb_data2;
        if (wb_en && idx == wb_reg1) return wb_data1;
`endif
        return rf[idx];
    endfunction

    // Scoreboard evaluated mid-cycle, for the transfers happening at the next posedge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", {24'd0, out_tag}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("out_tag", {24'd0, out_tag}, {24'd0, e.tag});
                    chk("out_a", out_a, e.a);
                    chk("out_b", out_b, e.b);
                end
            end
`ifdef OPERAND_BYPASS_EN
            if (wb_en) begin
                foreach (sb[i]) begin
                    if (sb[i].rs != 0) begin
                        if (sb[i].rs == wb_reg2)      sb[i].a = wb_data2;
                        else if (sb[i].rs == wb_reg1) sb[i].a = wb_data1;
                    end
                    if (sb[i].rt != 0) begin
                        if (sb[i].rt == wb_reg2)      sb[i].b = wb_data2;
                        else if (sb[i].rt == wb_reg1) sb[i].b = wb_data1;
                    end
                end
            end
`endif
            if (in_valid && in_ready) begin
                e.rs  = in_rs;
                e.rt  = in_rt;
                e.a   = model_sel(in_rs);
                e.b   = model_sel(in_rt);
                e.tag = in_tag;
                sb.push_back(e);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [4:0] rs, input logic [4:0] rt, input logic [7:0] tag);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_rs    = rs;
        in_rt    = rt;
        in_tag   = tag;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && sb.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", sb.size(), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        rf[3] = 32'h11; rf[4] = 32'h22; rf[5] = 32'h55; rf[7] = 32'h77;
        reset = 1'b0; in_valid = 1'b1; in_rs = 5'd3; in_rt = 5'd4; in_tag = 8'hEE;
        out_ready = 1'b1; wb_en = 1'b0; wb_reg1 = 0; wb_reg2 = 0; wb_data1 = 0; wb_data2 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_a", out_a, 32'd0);
        chk("rst_out_tag", {24'd0, out_tag}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;

        send(5'd3, 5'd4, 8'd1);
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_a", out_a, 32'h11);
        chk("t1_b", out_b, 32'h22);

        wb_en = 1'b1; wb_reg1 = 5'd0; wb_data1 = 32'hFFFF; wb_reg2 = 5'd0; wb_data2 = 32'hFFFF;
        send(5'd0, 5'd0, 8'd2);
        wb_en = 1'b0;
        chk("t2_a", out_a, 32'd0);
        chk("t2_b", out_b, 32'd0);

        wb_en = 1'b1; wb_reg1 = 5'd5; wb_data1 = 32'hA; wb_reg2 = 5'd5; wb_data2 = 32'hB;
        send(5'd5, 5'd6, 8'd3);
        wb_en = 1'b0;
`ifdef OPERAND_BYPASS_EN
        chk("t3_a_bypass", out_a, 32'hB);
`else
        chk("t3_a_nobypass", out_a, 32'h55);
`endif
        drain();

        out_ready = 1'b0;
        send(5'd1, 5'd2, 8'd10);
        send(5'd3, 5'd4, 8'd11);
        chk("t4_full_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1; in_rs = 5'd6; in_rt = 5'd8; in_tag = 8'd12;
        @(posedge clk); #1;
        chk("t4_still_full", {31'd0, in_ready}, 32'd0);
        chk("t4_head_tag", {24'd0, out_tag}, 32'd10);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_ready_rise", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        out_ready = 1'b0;
        send(5'd8, 5'd7, 8'd20);
        wb_en = 1'b1; wb_reg1 = 5'd7; wb_data1 = 32'h1234; wb_reg2 = 5'd9; wb_data2 = 32'h5555;
        @(posedge clk); #1;
        wb_en = 1'b0;
`ifdef OPERAND_BYPASS_EN
        chk("t5_refresh_b", out_b, 32'h1234);
`else
        chk("t5_held_b", out_b, 32'h77);
`endif
        out_ready = 1'b1;
        drain();

        out_ready = 1'b0;
        send(5'd1, 5'd1, 8'd30);
        send(5'd2, 5'd2, 8'd31);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_stale", {31'd0, out_valid}, 32'd0);
        chk("t6_ready_after", {31'd0, in_ready}, 32'd1);

        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            wb_en    = 1'($urandom_range(0, 1));
            wb_reg1  = 5'($urandom_range(0, 7));
            wb_reg2  = 5'($urandom_range(0, 7));
            wb_data1 = $urandom;
            wb_data2 = $urandom;
            send(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 8'(k + 64));
        end
        wb_en = 1'b0;
        rand_ready = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-read front end for the accelerator datapath: the consumer side of the dual-write-port register file. Accepts register-index requests over a valid/ready handshake and drives the register file's two combinational read ports. With bypass compiled in, it forwards same-cycle write-back data. It delivers both 32-bit operands through a two-entry skid buffer to the execute stage, with one cycle of latency.

## Interface
Parameters:
- DATA_W, 32, operand width
- ADDR_W, 5, register index width
- TAG_W, 8, opaque per-request tag carried alongside the operands

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  request can be accepted
- in_rs  in  ADDR_W  first source register index
- in_rt  in  ADDR_W  second source register index
- in_tag  in  TAG_W  request tag
- rf_read_register1  out  ADDR_W  register file read port 1 index (= in_rs)
- rf_read_register2  out  ADDR_W  register file read port 2 index (= in_rt)
- rf_read_data1  in  DATA_W  register file read port 1 data
- rf_read_data2  in  DATA_W  register file read port 2 data
- wb_en  in  1  write-back enable; same signal as the register file RegWrite
- wb_reg1  in  ADDR_W  write-back port 1 index
- wb_reg2  in  ADDR_W  write-back port 2 index
- wb_data1  in  DATA_W  write-back port 1 data
- wb_data2  in  DATA_W  write-back port 2 data
- out_valid  out  1  operands valid
- out_ready  in  1  consumer accepts operands
- out_a  out  DATA_W  operand for in_rs
- out_b  out  DATA_W  operand for in_rt
- out_tag  out  TAG_W  tag of the delivered operands

## Operation
- Accept happens when in_valid and in_ready are both high at a posedge. Retire happens when out_valid and out_ready are both high at a posedge.
- rf_read_register1/2 are combinational copies of in_rs/in_rt.
- Operand select per source, evaluated at accept:
  - index 0 yields 0;
  - else, with bypass, if wb_en and wb_reg2 matches, use wb_data2;
  - else, with bypass, if wb_en and wb_reg1 matches, use wb_data1;
  - else use rf_read_data.
- Port 2 has priority, matching the register file, where the port-2 write wins.
- The skid buffer is a FIFO with states EMPTY, ONE and TWO:
  - accept only: EMPTY→ONE, ONE→TWO;
  - retire only: TWO→ONE, ONE→EMPTY;
  - accept and retire together: state unchanged, with the head popped and the new entry pushed behind it.
- Output signals:
  - in_ready = (state != TWO), derived combinationally from registered state. It does not depend on out_ready.
  - out_valid = (state != EMPTY). out_a, out_b and out_tag come from the head entry.
- Held-entry refresh (bypass only): each posedge with wb_en, every occupied entry whose source index (nonzero) matches wb_reg2, else wb_reg1, has that operand replaced by the write data. Operands therefore never go stale while stalled.
- Reset state: EMPTY; all entry data, indices and tags are 0; out_valid=0, out_a=out_b=0, out_tag=0, in_ready=1.

## Timing
- Latency: request accepted at edge N gives out_valid high after edge N when the buffer was EMPTY. Registered outputs, no combinational in→out path.
- Throughput is one request per cycle with out_ready held high. With out_ready low, two requests are absorbed, then in_ready drops at the next edge.
- in_ready rises the cycle after a retire from TWO.
- Asserting reset mid-transfer immediately clears state and outputs asynchronously. In-flight requests are discarded, not replayed.
- Simultaneous accept and retire in state TWO cannot occur, because in_ready=0.
- A refresh and a retire of the same entry in one cycle is harmless; the refreshed value is dropped.

## Configuration
- OPERAND_BYPASS_EN defined: write-back forwarding at accept and held-entry refresh are enabled.
- OPERAND_BYPASS_EN undefined: operands are exactly rf_read_data (or 0 for index 0) at accept, with no refresh. The execute stage must then handle read-after-write hazards, e.g. by stalling.

## Structure
- Shared package holds:
  - ZERO_REG (5'd0);
  - the default widths;
  - the skid state enum {EMPTY, ONE, TWO}.
- Sub-module operand_skid_buffer: a two-entry FIFO storing {rs, rt, a, b, tag}. It exposes per-entry refresh inputs when bypass is enabled. The operand_fetch top level contains the operand-select muxing.

## Test plan
- Reset with in_valid=1 -> out_valid=0, out_a=0, in_ready=1 during reset. After release, request rs=3, rt=4 with RF r3=0x11, r4=0x22 -> next cycle out_a=0x11, out_b=0x22.
- rs=0, rt=0 with wb_en=1, wb_reg1=0, wb_data1=0xFFFF -> out_a=out_b=0.
- Bypass on, accept rs=5 in the same cycle as wb_en, wb_reg1=5, wb_data1=0xA, wb_reg2=5, wb_data2=0xB -> out_a=0xB. Bypass off -> out_a equals the old r5 value.
- out_ready=0, three back-to-back requests -> first two buffered, in_ready=0 for the third. Raise out_ready -> tags emerge in order with no loss or duplication.
- Bypass on, entry rt=7 held with out_ready=0, then write r7=0x1234 -> out_b=0x1234 on the next cycle.
- Assert reset while in state TWO -> out_valid=0 immediately. After release, in_ready=1 and no stale tags are emitted.
